// File: rtl/gd_pkg.sv
// Shared types and Q8.8 arithmetic helpers for the gradient-descent iteration controller.
package gd_pkg;

  localparam int unsigned NUM_AXES    = 4;
  localparam logic [15:0] Q88_MAX     = 16'h7FFF;
  localparam logic [15:0] Q88_MIN     = 16'h8000;
  localparam logic [15:0] TOL_DEFAULT = 16'h0010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_RELEASE,
    S_UPDATE,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    ST_CONVERGED = 2'd0,
    ST_MAX_ITER  = 2'd1,
    ST_OVERFLOW  = 2'd2,
    ST_TIMEOUT   = 2'd3
  } status_e;

  // Element [0] is axis a, [3] is axis d.
  typedef logic [NUM_AXES-1:0][15:0] point_t;

  // Signed Q8.8 add in 17 bits, clamped to the 16-bit range.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {a[15], a} + {b[15], b};
    if (sum[16] == sum[15]) begin
      return sum[15:0];
    end else if (sum[16]) begin
      return Q88_MIN;
    end else begin
      return Q88_MAX;
    end
  endfunction

  // Magnitude in 17 bits so that |16'h8000| is 32768 rather than wrapping.
  function automatic logic [16:0] abs17(input logic [15:0] d);
    logic [16:0] x;
    x = {d[15], d};
    return x[16] ? (~x + 17'd1) : x;
  endfunction

endpackage

// File: rtl/gd_iter_controller_if.sv
// Request/response handshake between the iteration controller and the function/gradient unit.
interface gd_iter_controller_if;

  logic        start_func;
  logic [15:0] a_out;
  logic [15:0] b_out;
  logic [15:0] c_out;
  logic [15:0] d_out;
  logic        func_done;
  logic [31:0] value;
  logic [15:0] a_diff;
  logic [15:0] b_diff;
  logic [15:0] c_diff;
  logic [15:0] d_diff;
  logic        overflow;

  modport master (
    output start_func, a_out, b_out, c_out, d_out,
    input  func_done, value, a_diff, b_diff, c_diff, d_diff, overflow
  );

  modport slave (
    input  start_func, a_out, b_out, c_out, d_out,
    output func_done, value, a_diff, b_diff, c_diff, d_diff, overflow
  );

endinterface

// File: rtl/gd_point_update.sv
// Next-point computation: four saturating Q8.8 adders and the all-axes convergence compare.
module gd_point_update
  import gd_pkg::*;
#(
  parameter logic [15:0] TOL = TOL_DEFAULT
) (
  input  point_t i_point,
  input  point_t i_diff,
  output point_t o_next,
  output logic   o_converged
);

  // NOTE: every variable written in always_comb gets a value before any branch,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    o_next      = '0;
    o_converged = 1'b1;
    for (int i = 0; i < NUM_AXES; i++) begin
      o_next[i] = sat_add16(i_point[i], i_diff[i]);
      if (abs17(i_diff[i]) > {1'b0, TOL}) begin
        o_converged = 1'b0;
      end
    end
  end

endmodule

// File: rtl/gd_iter_controller.sv
// Drives the function/gradient unit through a gradient-descent run: load point, 4-phase
// request/release handshake per evaluation, saturating update, and stop-condition detection.
module gd_iter_controller
  import gd_pkg::*;
#(
  parameter int unsigned MAX_ITER    = 16,
  parameter logic [15:0] TOL         = TOL_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  input  logic [15:0]                 a_init,
  input  logic [15:0]                 b_init,
  input  logic [15:0]                 c_init,
  input  logic [15:0]                 d_init,
  gd_iter_controller_if.master        fif,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  status,
  output logic [15:0]                 iter_count,
  output logic [31:0]                 last_value
);

  localparam int unsigned      TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [15:0]      ITER_LAST = 16'(MAX_ITER);

  state_e           r_state;
  status_e          r_status;
  point_t           r_point;
  point_t           r_diff;
  logic [31:0]      r_value;
  logic [31:0]      r_last;
  logic             r_ovf;
  logic             r_start;
  logic             r_busy;
  logic             r_done;
  logic             r_rearm;
  logic [15:0]      r_iter;
  logic [TMO_W-1:0] r_tmo;

  point_t           w_init;
  point_t           w_diff_in;
  point_t           w_next;
  logic             w_converged;
  logic             w_tmo_last;
  logic             w_finish;
  logic [15:0]      w_iter_next;
  status_e          w_fin_status;

  assign w_init      = {d_init, c_init, b_init, a_init};
  assign w_diff_in   = {fif.d_diff, fif.c_diff, fif.b_diff, fif.a_diff};
  assign w_iter_next = r_iter + 16'd1;
  assign w_tmo_last  = (r_tmo == TMO_LAST);

  gd_point_update #(
    .TOL (TOL)
  ) u_point_update (
    .i_point     (r_point),
    .i_diff      (r_diff),
    .o_next      (w_next),
    .o_converged (w_converged)
  );

  // Every way of ending a run funnels through one flag so DONE entry is handled in one place.
  always_comb begin
    w_finish     = 1'b0;
    w_fin_status = ST_TIMEOUT;
    case (r_state)
      S_REQ:     w_finish = !fif.func_done && w_tmo_last;
      S_RELEASE: w_finish =  fif.func_done && w_tmo_last;
      S_UPDATE: begin
        w_finish = r_ovf || w_converged || (w_iter_next == ITER_LAST);
        if (r_ovf) begin
          w_fin_status = ST_OVERFLOW;
        end else if (w_converged) begin
          w_fin_status = ST_CONVERGED;
        end else begin
          w_fin_status = ST_MAX_ITER;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // pre-edge values; a later assignment in the same block overrides an earlier one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_status <= ST_CONVERGED;
      r_point  <= '0;
      r_diff   <= '0;
      r_value  <= '0;
      r_last   <= '0;
      r_ovf    <= 1'b0;
      r_start  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rearm  <= 1'b0;
      r_iter   <= '0;
      r_tmo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          r_point <= w_init;
          r_iter  <= '0;
          r_tmo   <= '0;
          r_start <= 1'b1;
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (fif.func_done) begin
            r_diff  <= w_diff_in;
            r_value <= fif.value;
            r_ovf   <= fif.overflow;
            r_start <= 1'b0;
            r_tmo   <= '0;
            r_state <= S_RELEASE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_RELEASE: begin
          if (!fif.func_done) begin
            r_state <= S_UPDATE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_UPDATE: begin
          r_iter <= w_iter_next;
          // An overflowing evaluation leaves the point and the reported value untouched.
          if (!r_ovf) begin
            r_point <= w_next;
            r_last  <= r_value;
          end
          r_tmo   <= '0;
          r_start <= 1'b1;
          r_state <= S_REQ;
        end
        S_DONE: begin
          // A run level left high from the previous start must be seen low before re-arming.
          if (!run) begin
            r_rearm <= 1'b1;
          end else if (r_rearm) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_finish) begin
        r_state  <= S_DONE;
        r_start  <= 1'b0;
        r_busy   <= 1'b0;
        r_done   <= 1'b1;
        r_status <= w_fin_status;
        r_rearm  <= 1'b0;
      end
    end
  end

  assign fif.start_func = r_start;
  assign fif.a_out      = r_point[0];
  assign fif.b_out      = r_point[1];
  assign fif.c_out      = r_point[2];
  assign fif.d_out      = r_point[3];
  assign busy           = r_busy;
  assign done           = r_done;
  assign status         = r_status;
  assign iter_count     = r_iter;
  assign last_value     = r_last;

  a_start_within_busy: assert property (@(posedge clk) disable iff (!rst_n) r_start |-> r_busy);
  a_done_not_busy:     assert property (@(posedge clk) disable iff (!rst_n) r_done |-> !r_busy);

endmodule
